// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding.
// Used by the ALU-control decoder and the alu_exec_unit datapath.
package alu_pkg;

    typedef logic [2:0] alu_code_t;

    localparam alu_code_t ALU_AND = 3'b000;
    localparam alu_code_t ALU_OR  = 3'b001;
    localparam alu_code_t ALU_ADD = 3'b010;
    localparam alu_code_t ALU_SUB = 3'b100;
    localparam alu_code_t ALU_SLT = 3'b110;
    localparam alu_code_t ALU_MUL = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/mul_seq_core.sv
// Shift-add multiplier iteration engine: one partial-product step per load/step edge.
// Build option MUL_EARLY_EXIT_EN ends the sequence once the remaining multiplier bits are zero.
module mul_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] cur_mcand, cur_mplier, cur_acc, acc_next;
    logic [CW-1:0]    cur_cnt;

    // The load edge already performs the first iteration on the live operands,
    // so a one-iteration multiply completes without ever entering the MUL state.
    always_comb begin
        cur_mcand  = load ? a  : mcand;
        cur_mplier = load ? b  : mplier;
        cur_acc    = load ? '0 : acc;
        cur_cnt    = load ? '0 : cnt;
        acc_next   = cur_mplier[0] ? (cur_acc + cur_mcand) : cur_acc;
`ifdef MUL_EARLY_EXIT_EN
        last       = (cur_cnt == CNT_LAST) || ((cur_mplier >> 1) == '0);
`else
        last       = (cur_cnt == CNT_LAST);
`endif
    end

    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load || step) begin
            mcand  <= cur_mcand << 1;
            mplier <= cur_mplier >> 1;
            acc    <= acc_next;
            cnt    <= cur_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle AND/OR/ADD/SUB/SLT plus sequential MUL.
// Optional MUL_EARLY_EXIT_EN shortens multiplies to the multiplier's significant bits.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | accepting start; single-cycle ops complete from here
// ST_MUL  | shift-add multiply iterating; start ignored, busy high
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             illegal
);

    logic [0:0]       state;
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;

    assign mul_load = (state == ST_IDLE) && start && (alu_control == ALU_MUL);
    assign mul_step = (state == ST_MUL);
    assign busy     = (state == ST_MUL);

    mul_seq_core #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (src_a),
        .b       (src_b),
        .last    (mul_last),
        .product (mul_product)
    );

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (alu_control)
            ALU_AND: op_result = src_a & src_b;
            ALU_OR:  op_result = src_a | src_b;
            ALU_ADD: op_result = src_a + src_b;
            ALU_SUB: op_result = src_a - src_b;
            ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_MUL: op_result = mul_product;
            default: op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mul_load && !mul_last) begin
                            state <= ST_MUL;
                        end else begin
                            result  <= op_result;
                            zero    <= (op_result == '0);
                            illegal <= op_illegal;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (mul_last) begin
                        result  <= mul_product;
                        zero    <= (mul_product == '0);
                        illegal <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases then randomized ops vs. an arithmetic model.
// Define MUL_EARLY_EXIT_EN for both bench and RTL to check the early-exit build.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       alu_control = 3'b000;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [WIDTH-1:0] result;
    logic             zero, done, busy, illegal;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (result),
        .zero        (zero),
        .done        (done),
        .busy        (busy),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
        int               exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_lo = 0;
    int   busy_hi = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mul_iters(input logic [WIDTH-1:0] b);
        int n;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
`else
        n = WIDTH;
`endif
        return n;
    endfunction

    function automatic exp_t model(input logic [2:0] code, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] r;
        e.ill = 1'b0;
        case (code)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b100:  r = a - b;
            3'b110:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'b101:  r = a * b;
            default: begin r = '0; e.ill = 1'b1; end
        endcase
        e.res  = r;
        e.zero = (r == 0);
        e.exp_cyc = 0;
        return e;
    endfunction

    // Drives one start for one edge (caller decides what follows) and records the expectation.
    task automatic issue(input logic [2:0] code, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int c0, output int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; alu_control = code; src_a = a; src_b = b;
        c0  = cyc;
        lat = (code == 3'b101) ? mul_iters(b) : 1;
        e = model(code, a, b);
        e.exp_cyc = c0 + lat;
        sb.push_back(e);
        if (code == 3'b101) begin
            busy_lo = c0;
            busy_hi = c0 + lat;
        end
    endtask

    // Waits out a multiply so the next issue lands in its done cycle; optionally pokes an ADD mid-flight.
    task automatic wait_mul(input int c0, input int lat, input bit inject);
        while (cyc < c0 + lat - 1) begin
            @(negedge clk);
            start = 1'b0;
            src_a = $urandom; src_b = $urandom;
            if (inject && lat > 2 && cyc == c0 + 1) begin
                start = 1'b1; alu_control = 3'b010;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Monitor: pops on every done, flags unexpected/missing completions and busy errors.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("busy", busy, (cyc > busy_lo) && (cyc < busy_hi));
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", cyc, e.exp_cyc);
                        check("result", result, e.res);
                        check("zero", zero, e.zero);
                        check("illegal", illegal, e.ill);
                    end
                end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
                    e = sb.pop_front();
                    check("missing_done", 1'b0, 1'b1);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, lat;
        logic [2:0] code;
        logic [WIDTH-1:0] a, b;

        repeat (3) @(negedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // ADD 7+5
        issue(3'b010, 7, 5, c0, lat);
        idle(2);

        // back-to-back SUB then SLT
        issue(3'b100, 3, 3, c0, lat);
        issue(3'b110, 32'hFFFF_FFFF, 2, c0, lat);
        idle(2);

        // MUL 6*7 with an ignored start mid-flight, then an ADD in the done cycle
        issue(3'b101, 6, 7, c0, lat);
        wait_mul(c0, lat, 1'b1);
        issue(3'b010, 100, 23, c0, lat);
        idle(2);

        // MUL wrap cases
        issue(3'b101, 32'h8000_0000, 2, c0, lat);
        wait_mul(c0, lat, 1'b0);
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0, lat);
        wait_mul(c0, lat, 1'b0);
        idle(2);

        // reset during a multiply: aborted, no completion afterwards
        issue(3'b101, 6, 32'hF000_0007, c0, lat);
        while (cyc < c0 + 10) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        sb.delete();
        busy_lo = 0; busy_hi = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        idle(2);
        rst_n = 1'b1;
        idle(40);
        issue(3'b010, 32'hFFFF_FFFF, 1, c0, lat);
        idle(2);

        // illegal code, then a legal op clears illegal
        issue(3'b111, 9, 9, c0, lat);
        issue(3'b001, 32'h0F0, 32'h00F, c0, lat);
        issue(3'b011, 1, 2, c0, lat);
        idle(2);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            code = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                1:       begin a = $urandom; b = $urandom_range(0, 255); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            issue(code, a, b, c0, lat);
            if (code == 3'b101) wait_mul(c0, lat, 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        #2;
        if (sb.size() != 0) check("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
